// File: rtl/ad_sample_ctrl.sv
// ad_sample_ctrl
// Conversion sequencer for an external parallel-output ADC. A frame is
// started by `start` or by the continuous-mode period counter. The frame
// pulses CONVST, waits for BUSY to rise and fall, and then reads NUM_CH words
// over the CS/RD bus. Each word is presented on a valid/ready stream, and the
// read sequence stalls while a word is pending.
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : single-cycle frame request
//   cont              : continuous mode, auto-trigger every CONV_PERIOD clocks
//   status_clr        : single-cycle clear of the sticky status bits
//   ad_convst_n       : ADC conversion start (active-low, registered)
//   ad_busy           : ADC busy (asynchronous, synchronized internally)
//   ad_cs_n, ad_rd_n  : ADC chip select / read strobe (active-low, registered)
//   ad_db             : ADC data bus
//   sample_data/_ch   : captured word and its channel index
//   sample_valid/_ready : downstream handshake
//   status            : {miss, timeout, done, busy}
module ad_sample_ctrl #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 16,
  parameter int CONVST_LOW  = 4,
  parameter int RD_LOW      = 3,
  parameter int TIMEOUT     = 4096,
  parameter int CONV_PERIOD = 5000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont,
  input  logic              status_clr,
  output logic              ad_convst_n,
  input  logic              ad_busy,
  output logic              ad_cs_n,
  output logic              ad_rd_n,
  input  logic [DATA_W-1:0] ad_db,
  output logic [DATA_W-1:0] sample_data,
  output logic [3:0]        sample_ch,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [3:0]        status
);

  localparam int PH_MAX = (CONVST_LOW > RD_LOW) ? CONVST_LOW : RD_LOW;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WT_W   = $clog2(TIMEOUT + 1);
  localparam int PER_W  = $clog2(CONV_PERIOD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVST, S_WAIT_BH, S_WAIT_BL, S_READ, S_HOLD, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_cnt_q, ph_cnt_d;
  logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic [3:0]         ch_q, ch_d;
  logic               busy_meta_q, busy_s_q;
  logic               convst_n_q, convst_n_d;
  logic               rd_n_q, rd_n_d;
  logic [DATA_W-1:0]  sample_data_q, sample_data_d;
  logic [3:0]         sample_ch_q, sample_ch_d;
  logic               sample_valid_q, sample_valid_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               miss_q, miss_d;

  logic trig_auto, trig, accept, wait_expired, to_evt, capture;

  assign trig_auto    = cont && (per_cnt_q == PER_W'(CONV_PERIOD - 1));
  assign trig         = start || trig_auto;
  assign accept       = sample_valid_q && sample_ready;
  assign wait_expired = (wait_cnt_q == WT_W'(TIMEOUT - 1));

  // State register and all other flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      ph_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      per_cnt_q      <= '0;
      ch_q           <= '0;
      busy_meta_q    <= 1'b0;
      busy_s_q       <= 1'b0;
      convst_n_q     <= 1'b1;
      rd_n_q         <= 1'b1;
      sample_data_q  <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      miss_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ph_cnt_q       <= ph_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      per_cnt_q      <= per_cnt_d;
      ch_q           <= ch_d;
      busy_meta_q    <= ad_busy;
      busy_s_q       <= busy_meta_q;
      convst_n_q     <= convst_n_d;
      rd_n_q         <= rd_n_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      miss_q         <= miss_d;
    end
  end

  // Next-state logic, phase/wait counters and channel index
  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ch_d       = ch_q;
    to_evt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d    = S_CONVST;
          ch_d       = '0;
          ph_cnt_d   = '0;
          wait_cnt_d = '0;
        end
      end
      S_CONVST: begin
        if (ph_cnt_q == PH_W'(CONVST_LOW - 1)) begin
          state_d  = S_WAIT_BH;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_WAIT_BH, S_WAIT_BL: begin
        // One budget covers both BUSY edges; expiry abandons the frame.
        wait_cnt_d = wait_cnt_q + WT_W'(1);
        if (wait_expired) begin
          state_d = S_IDLE;
          to_evt  = 1'b1;
        end else if (state_q == S_WAIT_BH && busy_s_q) begin
          state_d = S_WAIT_BL;
        end else if (state_q == S_WAIT_BL && !busy_s_q) begin
          state_d  = S_READ;
          ph_cnt_d = '0;
        end
      end
      S_READ: begin
        if (ph_cnt_q == PH_W'(RD_LOW - 1)) begin
          state_d  = S_HOLD;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_HOLD: begin
        if (accept) begin
          if (ch_q == 4'(NUM_CH - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 4'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pins are decoded from the next state so they are registered
  // yet change on the same edge as the state.
  always_comb begin
    convst_n_d     = (state_d != S_CONVST);
    rd_n_d         = (state_d != S_READ);
    capture        = (state_q == S_READ) && (state_d == S_HOLD);
    sample_data_d  = capture ? ad_db : sample_data_q;
    sample_ch_d    = capture ? ch_q  : sample_ch_q;
    sample_valid_d = sample_valid_q;
    if (capture)     sample_valid_d = 1'b1;
    else if (accept) sample_valid_d = 1'b0;
    // Sticky bits: a set in the same cycle as status_clr wins.
    done_d    = (state_q == S_DONE) || (done_q && !status_clr);
    timeout_d = to_evt || (timeout_q && !status_clr);
    miss_d    = (trig && state_q != S_IDLE) || (miss_q && !status_clr);
    if (!cont || trig_auto) per_cnt_d = '0;
    else                    per_cnt_d = per_cnt_q + PER_W'(1);
  end

  assign ad_convst_n  = convst_n_q;
  assign ad_cs_n      = rd_n_q;
  assign ad_rd_n      = rd_n_q;
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign status       = {miss_q, timeout_q, done_q, (state_q != S_IDLE)};

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// Testbench for ad_sample_ctrl: directed scenarios with a behavioural ADC
// (BUSY pulse after CONVST, data 0x1000+word index) and a downstream sink.
module tb_ad_sample_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          status_clr = 1'b0;
  logic          ad_busy = 1'b0;
  logic          sample_ready = 1'b1;
  logic [DW-1:0] ad_db = '0;
  logic          ad_convst_n, ad_cs_n, ad_rd_n, sample_valid;
  logic [DW-1:0] sample_data;
  logic [3:0]    sample_ch, status;

  ad_sample_ctrl #(.NUM_CH(8), .DATA_W(DW), .CONVST_LOW(4), .RD_LOW(3),
                   .TIMEOUT(4096), .CONV_PERIOD(2000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cont(cont),
    .status_clr(status_clr), .ad_convst_n(ad_convst_n), .ad_busy(ad_busy),
    .ad_cs_n(ad_cs_n), .ad_rd_n(ad_rd_n), .ad_db(ad_db),
    .sample_data(sample_data), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .status(status)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ADC BUSY model: high for 100 clocks after CONVST rises
  bit   busy_en = 1'b1;
  int   busy_cnt = 0;
  logic cv_prev_b = 1'b1;
  always @(posedge clk) begin
    #1;
    if (cv_prev_b == 1'b0 && ad_convst_n == 1'b1 && busy_en) busy_cnt = 100;
    cv_prev_b = ad_convst_n;
    ad_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  // Downstream sink: mode 0 always ready, 1 ready one cycle in three
  int rdy_mode = 0;
  int rc = 0;
  always @(posedge clk) begin
    #1;
    rc++;
    sample_ready = (rdy_mode == 0) ? 1'b1 : ((rc % 3) == 0);
  end

  // ADC data model: each RD strobe presents 0x1000 + word index in frame
  int frame_rd = 0;
  int rd_strobes = 0;
  always @(negedge ad_convst_n or negedge ad_rd_n) begin
    if (ad_rd_n) frame_rd = 0;
    else begin
      ad_db = 16'h1000 + 16'(frame_rd);
      frame_rd++;
      rd_strobes++;
    end
  end

  // Bus monitor
  int rd_run = 0, rd_bad = 0, cv_run = 0, cv_bad = 0, cv_cnt = 0;
  int pend_viol = 0, cs_viol = 0, fall_cnt = 0, last_fall = 0;
  logic cv_prev_m = 1'b1;
  logic [DW-1:0] q_data[$];
  logic [3:0]    q_ch[$];
  always @(negedge clk) begin
    if (ad_rd_n === 1'b0) rd_run++;
    else if (rd_run != 0) begin
      if (rd_run != 3) rd_bad++;
      rd_run = 0;
    end
    if (ad_convst_n === 1'b0) cv_run++;
    else if (cv_run != 0) begin
      if (cv_run != 4) cv_bad++;
      cv_cnt++;
      cv_run = 0;
    end
    if (cv_prev_m === 1'b1 && ad_convst_n === 1'b0) begin
      fall_cnt++;
      last_fall = cyc;
    end
    cv_prev_m = ad_convst_n;
    if (sample_valid === 1'b1 && ad_rd_n === 1'b0) pend_viol++;
    if (ad_cs_n !== ad_rd_n) cs_viol++;
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      q_data.push_back(sample_data);
      q_ch.push_back(sample_ch);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 status_clr = 1'b1;
    @(posedge clk); #1 status_clr = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (status[0] == 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (ad_convst_n !== 1'b1) begin miscompares++; $display("FAIL rst_convst_n: got %b expected 1", ad_convst_n); end
    vectors++; if (ad_cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_cs_n: got %b expected 1", ad_cs_n); end
    vectors++; if (ad_rd_n !== 1'b1) begin miscompares++; $display("FAIL rst_rd_n: got %b expected 1", ad_rd_n); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
    vectors++; if (sample_data !== 16'h0) begin miscompares++; $display("FAIL rst_data: got %h expected 0000", sample_data); end
    vectors++; if (sample_ch !== 4'h0) begin miscompares++; $display("FAIL rst_ch: got %h expected 0", sample_ch); end
    vectors++; if (status !== 4'b0000) begin miscompares++; $display("FAIL rst_status: got %b expected 0000", status); end
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single_frame();
    int b, rs, rb, cvb, cvc, cvs;
    bit ok;
    rdy_mode = 0; busy_en = 1'b1;
    b = q_data.size(); rs = rd_strobes; rb = rd_bad; cvb = cv_bad; cvc = cv_cnt; cvs = cs_viol;
    pulse_start();
    @(negedge clk);
    vectors++; if (ad_convst_n !== 1'b0) begin miscompares++; $display("FAIL frame_convst_edge: got %b expected 0", ad_convst_n); end
    vectors++; if (status !== 4'b0001) begin miscompares++; $display("FAIL frame_status_busy: got %b expected 0001", status); end
    wait_idle(1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL frame_end: got timeout expected idle"); end
    vectors++; if (status !== 4'b0010) begin miscompares++; $display("FAIL frame_status_done: got %b expected 0010", status); end
    vectors++; if (q_data.size() - b != 8) begin miscompares++; $display("FAIL frame_words: got %0d expected 8", q_data.size() - b); end
    for (int i = 0; i < 8 && b + i < q_data.size(); i++) begin
      vectors++; if (q_data[b+i] !== 16'h1000 + 16'(i)) begin miscompares++; $display("FAIL frame_data%0d: got %h expected %h", i, q_data[b+i], 16'h1000 + 16'(i)); end
      vectors++; if (q_ch[b+i] !== 4'(i)) begin miscompares++; $display("FAIL frame_ch%0d: got %0d expected %0d", i, q_ch[b+i], i); end
    end
    vectors++; if (rd_strobes - rs != 8) begin miscompares++; $display("FAIL frame_rd_strobes: got %0d expected 8", rd_strobes - rs); end
    vectors++; if (rd_bad != rb) begin miscompares++; $display("FAIL frame_rd_low_len: got %0d bad strobes expected 0", rd_bad - rb); end
    vectors++; if (cv_cnt - cvc != 1 || cv_bad != cvb) begin miscompares++; $display("FAIL frame_convst_len: got %0d pulses %0d bad expected 1 pulse 0 bad", cv_cnt - cvc, cv_bad - cvb); end
    vectors++; if (cs_viol != cvs) begin miscompares++; $display("FAIL frame_cs_rd: got %0d differing cycles expected 0", cs_viol - cvs); end
  endtask

  task automatic test_backpressure();
    int b, rs, rb, pv;
    bit ok;
    pulse_clr();
    @(negedge clk);
    vectors++; if (status !== 4'b0000) begin miscompares++; $display("FAIL bp_clear: got %b expected 0000", status); end
    rdy_mode = 1;
    b = q_data.size(); rs = rd_strobes; rb = rd_bad; pv = pend_viol;
    pulse_start();
    wait_idle(2000, ok);
    rdy_mode = 0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_end: got timeout expected idle"); end
    vectors++; if (status !== 4'b0010) begin miscompares++; $display("FAIL bp_status: got %b expected 0010", status); end
    vectors++; if (q_data.size() - b != 8) begin miscompares++; $display("FAIL bp_words: got %0d expected 8", q_data.size() - b); end
    for (int i = 0; i < 8 && b + i < q_data.size(); i++) begin
      vectors++; if (q_data[b+i] !== 16'h1000 + 16'(i) || q_ch[b+i] !== 4'(i)) begin miscompares++; $display("FAIL bp_word%0d: got %h/ch%0d expected %h/ch%0d", i, q_data[b+i], q_ch[b+i], 16'h1000 + 16'(i), i); end
    end
    vectors++; if (pend_viol != pv) begin miscompares++; $display("FAIL bp_rd_while_pending: got %0d cycles expected 0", pend_viol - pv); end
    vectors++; if (rd_strobes - rs != 8 || rd_bad != rb) begin miscompares++; $display("FAIL bp_strobes: got %0d strobes %0d bad expected 8 and 0", rd_strobes - rs, rd_bad - rb); end
  endtask

  task automatic test_timeout();
    int rs, wclks;
    bit ok;
    pulse_clr();
    busy_en = 1'b0;
    rs = rd_strobes; wclks = 0; ok = 1'b0;
    pulse_start();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (status[0] == 1'b0) begin ok = 1'b1; break; end
      if (ad_convst_n == 1'b1) wclks++;
    end
    busy_en = 1'b1;
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_end: got still busy expected idle"); end
    vectors++; if (wclks != 4096) begin miscompares++; $display("FAIL to_wait_clks: got %0d expected 4096", wclks); end
    vectors++; if (status !== 4'b0100) begin miscompares++; $display("FAIL to_status: got %b expected 0100", status); end
    vectors++; if (rd_strobes != rs) begin miscompares++; $display("FAIL to_no_reads: got %0d strobes expected 0", rd_strobes - rs); end
    repeat (5) @(posedge clk);
    pulse_clr();
    @(negedge clk);
    vectors++; if (status !== 4'b0000) begin miscompares++; $display("FAIL to_clear: got %b expected 0000", status); end
  endtask

  task automatic test_miss();
    int b;
    bit ok;
    rdy_mode = 0;
    b = q_data.size();
    pulse_start();
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    vectors++; if (status !== 4'b1001) begin miscompares++; $display("FAIL miss_set: got %b expected 1001", status); end
    @(posedge clk); #1 start = 1'b1; status_clr = 1'b1;
    @(posedge clk); #1 start = 1'b0; status_clr = 1'b0;
    @(negedge clk);
    vectors++; if (status !== 4'b1001) begin miscompares++; $display("FAIL miss_set_wins: got %b expected 1001", status); end
    pulse_clr();
    @(negedge clk);
    vectors++; if (status !== 4'b0001) begin miscompares++; $display("FAIL miss_clear: got %b expected 0001", status); end
    wait_idle(1000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL miss_frame_end: got timeout expected idle"); end
    vectors++; if (status !== 4'b0010) begin miscompares++; $display("FAIL miss_frame_status: got %b expected 0010", status); end
    vectors++; if (q_data.size() - b != 8) begin miscompares++; $display("FAIL miss_frame_words: got %0d expected 8", q_data.size() - b); end
    for (int i = 0; i < 8 && b + i < q_data.size(); i++) begin
      vectors++; if (q_data[b+i] !== 16'h1000 + 16'(i) || q_ch[b+i] !== 4'(i)) begin miscompares++; $display("FAIL miss_word%0d: got %h/ch%0d expected %h/ch%0d", i, q_data[b+i], q_ch[b+i], 16'h1000 + 16'(i), i); end
    end
  endtask

  task automatic test_cont();
    int fc, c0, c1, t1;
    bit ok;
    pulse_clr();
    fc = fall_cnt;
    @(posedge clk); #1 cont = 1'b1; c0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 2100; i++) begin @(negedge clk); if (fall_cnt == fc + 1) begin ok = 1'b1; break; end end
    vectors++; if (!ok || last_fall - c0 != 2000) begin miscompares++; $display("FAIL cont_first: got %0d clks expected 2000", last_fall - c0); end
    t1 = last_fall; ok = 1'b0;
    for (int i = 0; i < 2100; i++) begin @(negedge clk); if (fall_cnt == fc + 2) begin ok = 1'b1; break; end end
    vectors++; if (!ok || last_fall - t1 != 2000) begin miscompares++; $display("FAIL cont_period: got %0d clks expected 2000", last_fall - t1); end
    @(posedge clk); #1 cont = 1'b0;
    repeat (500) @(posedge clk);
    #1 cont = 1'b1; c1 = cyc; ok = 1'b0;
    for (int i = 0; i < 2100; i++) begin @(negedge clk); if (fall_cnt == fc + 3) begin ok = 1'b1; break; end end
    vectors++; if (!ok || last_fall - c1 != 2000) begin miscompares++; $display("FAIL cont_restart: got %0d clks expected 2000", last_fall - c1); end
    @(posedge clk); #1 cont = 1'b0;
    wait_idle(1000, ok);
    vectors++; if (!ok || status !== 4'b0010) begin miscompares++; $display("FAIL cont_status: got %b expected 0010", status); end
  endtask

  task automatic test_reset_mid_read();
    int b;
    bit ok;
    pulse_clr();
    rdy_mode = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_ch == 4'd2 && ad_rd_n == 1'b0) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_reach_read: got no read of ch3 expected one"); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (ad_rd_n !== 1'b1 || ad_cs_n !== 1'b1) begin miscompares++; $display("FAIL rr_strobes: got rd=%b cs=%b expected 1 1", ad_rd_n, ad_cs_n); end
    vectors++; if (sample_valid !== 1'b0 || sample_data !== 16'h0 || sample_ch !== 4'h0) begin miscompares++; $display("FAIL rr_sample: got v=%b d=%h ch=%0d expected 0 0000 0", sample_valid, sample_data, sample_ch); end
    vectors++; if (status !== 4'b0000 || ad_convst_n !== 1'b1) begin miscompares++; $display("FAIL rr_status: got %b convst=%b expected 0000 1", status, ad_convst_n); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    b = q_data.size();
    pulse_start();
    wait_idle(1000, ok);
    vectors++; if (!ok || status !== 4'b0010) begin miscompares++; $display("FAIL rr_frame_status: got %b expected 0010", status); end
    vectors++; if (q_data.size() - b != 8) begin miscompares++; $display("FAIL rr_words: got %0d expected 8", q_data.size() - b); end
    for (int i = 0; i < 8 && b + i < q_data.size(); i++) begin
      vectors++; if (q_data[b+i] !== 16'h1000 + 16'(i) || q_ch[b+i] !== 4'(i)) begin miscompares++; $display("FAIL rr_word%0d: got %h/ch%0d expected %h/ch%0d", i, q_data[b+i], q_ch[b+i], 16'h1000 + 16'(i), i); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_timeout();
    test_miss();
    test_cont();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad_sample_ctrl.md
# ad_sample_ctrl

Conversion sequencer for the external parallel-output ADC. It pulses CONVST, waits on BUSY, and reads NUM_CH words over the CS/RD bus. Each word is handed downstream on a valid/ready stream. The block also drives the 4-bit `status` vector that the AD status input port samples for the CPU.

## Interface
Parameters:
- NUM_CH, 8: words read per conversion frame (1..16).
- DATA_W, 16: ADC data bus width.
- CONVST_LOW, 4: clocks `ad_convst_n` is held low (>=1).
- RD_LOW, 3: clocks `ad_cs_n`/`ad_rd_n` are held low per word (>=1).
- TIMEOUT, 4096: max clocks spent waiting on BUSY per frame.
- CONV_PERIOD, 5000: clocks between auto-triggers in continuous mode (>= worst-case frame length).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: single-cycle frame request.
- cont, in, 1: continuous mode, auto-trigger every CONV_PERIOD clocks.
- status_clr, in, 1: single-cycle clear of the sticky status bits.
- ad_convst_n, out, 1: ADC conversion start, active-low.
- ad_busy, in, 1: ADC busy, asynchronous to clk.
- ad_cs_n, out, 1: ADC chip select, active-low.
- ad_rd_n, out, 1: ADC read strobe, active-low.
- ad_db, in, DATA_W: ADC data bus.
- sample_data, out, DATA_W: captured word.
- sample_ch, out, 4: channel index of `sample_data`.
- sample_valid, out, 1: `sample_data`/`sample_ch` valid.
- sample_ready, in, 1: downstream accepts the word.
- status, out, 4: {miss, timeout, done, busy}. Feeds the AD status input port.

## Operation
- Trigger sources:
  - `start` is sampled every clk.
  - While `cont`=1, a period counter raises an internal trigger every CONV_PERIOD clocks. The counter is cleared and held at 0 while `cont`=0.
- `ad_busy` passes through a 2-FF synchronizer. Only the synchronized copy `busy_s` is used.
- FSM states and transitions:
  - IDLE: leaves on a trigger → CONVST, with ch=0.
  - CONVST: `ad_convst_n`=0 for CONVST_LOW cycles → WAIT_BH.
  - WAIT_BH: waits for `busy_s`=1 → WAIT_BL.
  - WAIT_BL: waits for `busy_s`=0 → READ.
  - READ: `ad_cs_n`=`ad_rd_n`=0 for RD_LOW cycles. On the edge ending the last low cycle: `sample_data`←`ad_db`, `sample_ch`←ch, `sample_valid`←1. → HOLD.
  - HOLD: strobes high. Waits for `sample_valid`&&`sample_ready`.
    - On acceptance with ch<NUM_CH-1: ch←ch+1 → READ. This gives at least 1 high cycle between reads.
    - On acceptance with ch=NUM_CH-1: → DONE.
  - DONE: sets done → IDLE.
- Backpressure stalls the read sequence. ADC data is held by the device, so no word is ever dropped.
- Timeout:
  - A wait counter runs in WAIT_BH and WAIT_BL combined and is cleared on CONVST entry.
  - When it reaches TIMEOUT: set timeout sticky and go to IDLE. No further reads occur, and done is not set.
- status[0] busy is 1 whenever the FSM is not in IDLE. It is combinational from the state register.
- status[1] done is sticky. It is set in DONE.
- status[2] timeout is sticky.
- status[3] miss is sticky. It is set when any trigger (`start` or auto) arrives while the FSM is not in IDLE. The trigger is discarded.
- Sticky bits clear on `status_clr`. If a set and `status_clr` occur in the same cycle, the set wins.
- A `start` and an auto-trigger in the same IDLE cycle start one frame, and miss is not set.

## Timing
- Reset values (asynchronous, immediate, including mid-frame):
  - State=IDLE, ch=0, all counters 0.
  - `ad_convst_n`=1, `ad_cs_n`=1, `ad_rd_n`=1.
  - `sample_valid`=0, `sample_data`=0, `sample_ch`=0, `status`=0.
- `start` high at edge N: the FSM is in CONVST after edge N, so `ad_convst_n` is low from cycle N+1 for exactly CONVST_LOW cycles.
- Every control output is registered. There are no glitches on `ad_*` pins.
- BUSY edges are seen 2–3 clocks after the pin toggles.
- `sample_valid` rises on the same edge that `ad_rd_n`/`ad_cs_n` return high.
- `sample_valid` falls on the edge following the accept cycle. If `sample_ready` is held 1, the next RD low begins on that same edge.
- Minimum frame length in clocks, with `sample_ready`=1 and an immediate BUSY: CONVST_LOW + sync latency + NUM_CH·(RD_LOW+1) + 1.
- `status` updates one clock after the causing event. The done bit sets on the edge leaving DONE.

## Test plan
- Defaults, `start` pulse, BUSY model high for 100 clks after CONVST rises, `ad_db`=0x1000+ch, `sample_ready`=1 → 8 words 0x1000..0x1007 with ch 0..7; `ad_convst_n` low exactly 4 clks; each RD low 3 clks; status goes 0001 during the frame, then 0010.
- Same frame with `sample_ready` toggling 1-in-3 → identical data and order, no lost words; `ad_rd_n` stays high while a word is pending.
- BUSY tied low, `start` → after 4096 wait clocks status=0100; no RD strobes; later `status_clr` → status=0000.
- `start` pulsed again mid-frame → miss set (status bit3=1); frame still completes with 8 words; `status_clr` in the same cycle as a miss event → miss remains 1.
- `cont`=1, CONV_PERIOD=2000 → frames start every 2000 clks; period counter resets when `cont` drops.
- `reset_n` asserted during READ → `ad_rd_n`/`ad_cs_n` high and `sample_valid`=0 immediately; after release a new `start` yields a clean frame from ch 0.
